// File: rtl/nx_ia_mem_port_arb_pkg.sv
// Shared types for the SRAM port arbiter: read-tag bundle and owner encoding.
// Ports: none (package only).
package nx_ia_mem_arbPKG;

    typedef enum logic {
        OWN_HW = 1'b0,
        OWN_SW = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner_sw;
        logic   is_cmp;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{
        vld:      1'b0,
        owner_sw: OWN_HW,
        is_cmp:   1'b0
    };

    // Non-returning accesses collapse to TAG_NONE so stale owner bits never leak.
    function automatic rd_tag_t mk_tag(
        input logic vld,
        input logic sw,
        input logic cmp
    );
        rd_tag_t t;
        t = TAG_NONE;
        if (vld) begin
            t.vld      = 1'b1;
            t.owner_sw = sw ? OWN_SW : OWN_HW;
            t.is_cmp   = cmp;
        end
        return t;
    endfunction

endpackage

// File: rtl/nx_ia_rd_tag_pipe.sv
// Read-tag delay line: a tag entered with an access exits DEPTH cycles later,
// aligned with the SRAM read data. Ports: clk, rst_n, i_tag (in), o_tag (exit).
module nx_ia_rd_tag_pipe
    import nx_ia_mem_arbPKG::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/nx_ia_mem_port_arb.sv
// Arbitrates a single-port SRAM between the datapath (hw) and indirect-access (sw) ports.
// Ports: sw_* request/response, yield, hw_* request/response, mem_* SRAM interface.
module nx_ia_mem_port_arb
    import nx_ia_mem_arbPKG::*;
#(
    parameter int unsigned N_ADDR_BITS   = 15,
    parameter int unsigned N_DATA_BITS   = 64,
    parameter int unsigned N_AINDEX_BITS = 14,
    parameter int unsigned RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sw_cs,
    input  logic                     sw_ce,
    input  logic                     sw_we,
    input  logic [N_ADDR_BITS-1:0]   sw_add,
    input  logic [N_DATA_BITS-1:0]   sw_wdat,
    input  logic                     yield,
    output logic                     grant,
    output logic                     rsp,
    output logic [N_DATA_BITS-1:0]   sw_rdat,
    output logic                     sw_match,
    output logic [N_AINDEX_BITS-1:0] sw_aindex,
    input  logic                     hw_req,
    input  logic                     hw_we,
    input  logic [N_ADDR_BITS-1:0]   hw_add,
    input  logic [N_DATA_BITS-1:0]   hw_wdat,
    output logic                     hw_gnt,
    output logic                     hw_rvld,
    output logic [N_DATA_BITS-1:0]   hw_rdat,
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic [N_ADDR_BITS-1:0]   mem_add,
    output logic [N_DATA_BITS-1:0]   mem_wdat,
    input  logic [N_DATA_BITS-1:0]   mem_rdat
);

    localparam int unsigned AW  = N_ADDR_BITS;
    localparam int unsigned DW  = N_DATA_BITS;
    localparam int unsigned AIW = N_AINDEX_BITS;

    logic           w_sw_win;
    logic           w_hw_win;
    logic           w_sw_rd;
    logic           w_hw_rd;
    rd_tag_t        w_tag_in;
    rd_tag_t        w_tag_out;

    logic [DW-1:0]  r_cmp_wdat;
    logic [AIW-1:0] r_cmp_idx;
    logic           r_rsp;
    logic           r_hw_rvld;
    logic [DW-1:0]  r_sw_rdat;
    logic           r_sw_match;
    logic [AIW-1:0] r_sw_aindex;
    logic [DW-1:0]  r_hw_rdat;

    // yield lets a starving sw port pre-empt hw; otherwise hw has priority.
    assign w_sw_win = sw_cs && (yield || !hw_req);
    assign w_hw_win = hw_req && !w_sw_win;

    assign grant  = w_sw_win;
    assign hw_gnt = w_hw_win;

    // A compare is a read on the SRAM side, so sw_ce masks sw_we.
    assign w_sw_rd = w_sw_win && (sw_ce || !sw_we);
    assign w_hw_rd = w_hw_win && !hw_we;

    always_comb begin
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_add  = '0;
        mem_wdat = '0;
        if (w_sw_win) begin
            mem_cs   = 1'b1;
            mem_we   = sw_we && !sw_ce;
            mem_add  = sw_add;
            mem_wdat = sw_ce ? '0 : sw_wdat;
        end else if (w_hw_win) begin
            mem_cs   = 1'b1;
            mem_we   = hw_we;
            mem_add  = hw_add;
            mem_wdat = hw_wdat;
        end
    end

    assign w_tag_in = mk_tag(
        w_sw_rd || w_hw_rd,
        w_sw_win,
        w_sw_win && sw_ce
    );

    nx_ia_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Only one compare is ever in flight, so a single holding slot suffices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_wdat <= '0;
            r_cmp_idx  <= '0;
        end else if (w_sw_win && sw_ce) begin
            r_cmp_wdat <= sw_wdat;
            r_cmp_idx  <= sw_add[AIW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hw_rvld <= 1'b0;
            r_hw_rdat <= '0;
        end else begin
            r_hw_rvld <= 1'b0;
            if (w_tag_out.vld && (w_tag_out.owner_sw == OWN_HW)) begin
                r_hw_rvld <= 1'b1;
                r_hw_rdat <= mem_rdat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp       <= 1'b0;
            r_sw_rdat   <= '0;
            r_sw_match  <= 1'b0;
            r_sw_aindex <= '0;
        end else begin
            r_rsp <= 1'b0;
            if (w_tag_out.vld && (w_tag_out.owner_sw == OWN_SW)) begin
                r_rsp <= 1'b1;
                if (w_tag_out.is_cmp) begin
                    r_sw_match  <= (mem_rdat == r_cmp_wdat);
                    r_sw_aindex <= r_cmp_idx;
                end else begin
                    r_sw_rdat <= mem_rdat;
                end
            end
        end
    end

    assign rsp       = r_rsp;
    assign hw_rvld   = r_hw_rvld;
    assign sw_rdat   = r_sw_rdat;
    assign sw_match  = r_sw_match;
    assign sw_aindex = r_sw_aindex;
    assign hw_rdat   = r_hw_rdat;

endmodule

// File: tb/tb_nx_ia_mem_port_arb.sv
// Directed bench for nx_ia_mem_port_arb: one instance at RD_LATENCY=1, one at 3,
// each backed by a behavioural SRAM with matching read latency.
module tb_nx_ia_mem_port_arb;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;

    logic        sw_cs1, sw_ce1, sw_we1, yield1;
    logic [14:0] sw_add1;
    logic [63:0] sw_wdat1;
    logic        grant1, rsp1, sw_match1;
    logic [63:0] sw_rdat1;
    logic [13:0] sw_aindex1;
    logic        hw_req1, hw_we1;
    logic [14:0] hw_add1;
    logic [63:0] hw_wdat1;
    logic        hw_gnt1, hw_rvld1;
    logic [63:0] hw_rdat1;
    logic        mem_cs1, mem_we1;
    logic [14:0] mem_add1;
    logic [63:0] mem_wdat1, mem_rdat1;

    logic        sw_cs3, sw_ce3, sw_we3, yield3;
    logic [14:0] sw_add3;
    logic [63:0] sw_wdat3;
    logic        grant3, rsp3, sw_match3;
    logic [63:0] sw_rdat3;
    logic [13:0] sw_aindex3;
    logic        hw_req3, hw_we3;
    logic [14:0] hw_add3;
    logic [63:0] hw_wdat3;
    logic        hw_gnt3, hw_rvld3;
    logic [63:0] hw_rdat3;
    logic        mem_cs3, mem_we3;
    logic [14:0] mem_add3;
    logic [63:0] mem_wdat3, mem_rdat3;

    nx_ia_mem_port_arb #(
        .N_ADDR_BITS(15), .N_DATA_BITS(64),
        .N_AINDEX_BITS(14), .RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .sw_cs(sw_cs1), .sw_ce(sw_ce1), .sw_we(sw_we1),
        .sw_add(sw_add1), .sw_wdat(sw_wdat1), .yield(yield1),
        .grant(grant1), .rsp(rsp1), .sw_rdat(sw_rdat1),
        .sw_match(sw_match1), .sw_aindex(sw_aindex1),
        .hw_req(hw_req1), .hw_we(hw_we1), .hw_add(hw_add1),
        .hw_wdat(hw_wdat1), .hw_gnt(hw_gnt1), .hw_rvld(hw_rvld1),
        .hw_rdat(hw_rdat1), .mem_cs(mem_cs1), .mem_we(mem_we1),
        .mem_add(mem_add1), .mem_wdat(mem_wdat1), .mem_rdat(mem_rdat1)
    );

    nx_ia_mem_port_arb #(
        .N_ADDR_BITS(15), .N_DATA_BITS(64),
        .N_AINDEX_BITS(14), .RD_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .sw_cs(sw_cs3), .sw_ce(sw_ce3), .sw_we(sw_we3),
        .sw_add(sw_add3), .sw_wdat(sw_wdat3), .yield(yield3),
        .grant(grant3), .rsp(rsp3), .sw_rdat(sw_rdat3),
        .sw_match(sw_match3), .sw_aindex(sw_aindex3),
        .hw_req(hw_req3), .hw_we(hw_we3), .hw_add(hw_add3),
        .hw_wdat(hw_wdat3), .hw_gnt(hw_gnt3), .hw_rvld(hw_rvld3),
        .hw_rdat(hw_rdat3), .mem_cs(mem_cs3), .mem_we(mem_we3),
        .mem_add(mem_add3), .mem_wdat(mem_wdat3), .mem_rdat(mem_rdat3)
    );

    // Behavioural SRAMs with a backdoor preload port.
    logic        bd_we1, bd_we3;
    logic [14:0] bd_add;
    logic [63:0] bd_dat;
    logic [63:0] mem1 [0:32767];
    logic [63:0] mem3 [0:32767];
    logic [63:0] rp1;
    logic [63:0] rp3 [3];

    always @(posedge clk) begin
        if (bd_we1) mem1[bd_add] <= bd_dat;
        if (mem_cs1 && mem_we1) mem1[mem_add1] <= mem_wdat1;
        if (mem_cs1 && !mem_we1) rp1 <= mem1[mem_add1];
    end
    assign mem_rdat1 = rp1;

    always @(posedge clk) begin
        if (bd_we3) mem3[bd_add] <= bd_dat;
        if (mem_cs3 && mem_we3) mem3[mem_add3] <= mem_wdat3;
        rp3[0] <= (mem_cs3 && !mem_we3) ? mem3[mem_add3] : 64'h0;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mem_rdat3 = rp3[2];

    // Event monitors, sampled on the falling edge.
    int  wr_cnt1;
    int  pulse_cnt3;
    int  cmp_viol;
    logic cmp_pend;

    initial begin
        wr_cnt1    = 0;
        pulse_cnt3 = 0;
        cmp_viol   = 0;
        cmp_pend   = 1'b0;
    end

    always @(negedge clk) begin
        if (mem_cs1 && mem_we1) wr_cnt1 = wr_cnt1 + 1;
        if (rsp3 || hw_rvld3) pulse_cnt3 = pulse_cnt3 + 1;
        if (!rst_n) begin
            cmp_pend = 1'b0;
        end else begin
            if (rsp1) cmp_pend = 1'b0;
            if (grant1 && sw_ce1) begin
                if (cmp_pend) cmp_viol = cmp_viol + 1;
                cmp_pend = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int which, input logic [14:0] a, input logic [63:0] d);
        bd_add = a;
        bd_dat = d;
        bd_we1 = (which == 1);
        bd_we3 = (which == 3);
        tick();
        bd_we1 = 1'b0;
        bd_we3 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_run++;
        if ({rsp1, hw_rvld1, sw_match1, rsp3, hw_rvld3, sw_match3} !== 6'b0) begin
            $display("FAIL reset_pulses: got %b want 000000",
                {rsp1, hw_rvld1, sw_match1, rsp3, hw_rvld3, sw_match3});
            n_fail++;
        end
        n_run++;
        if ({sw_rdat1, hw_rdat1, sw_rdat3, hw_rdat3} !== 256'h0) begin
            $display("FAIL reset_data: got %h %h %h %h want 0",
                sw_rdat1, hw_rdat1, sw_rdat3, hw_rdat3);
            n_fail++;
        end
        n_run++;
        if ({sw_aindex1, sw_aindex3} !== 28'h0) begin
            $display("FAIL reset_aindex: got %h %h want 0", sw_aindex1, sw_aindex3);
            n_fail++;
        end
        n_run++;
        if ({grant1, hw_gnt1, mem_cs1, mem_we1} !== 4'b0) begin
            $display("FAIL idle_mux: got %b want 0000", {grant1, hw_gnt1, mem_cs1, mem_we1});
            n_fail++;
        end
    endtask

    task automatic test_idle_read();
        tick();
        sw_cs1 = 1'b1; sw_we1 = 1'b0; sw_ce1 = 1'b0; sw_add1 = 15'h10;
        #1;
        n_run++;
        if ({grant1, hw_gnt1, mem_cs1, mem_we1} !== 4'b1010 || mem_add1 !== 15'h10) begin
            $display("FAIL idle_grant: got g=%b h=%b cs=%b we=%b add=%h want 1 0 1 0 0010",
                grant1, hw_gnt1, mem_cs1, mem_we1, mem_add1);
            n_fail++;
        end
        tick();
        sw_cs1 = 1'b0;
        n_run++;
        if (rsp1 !== 1'b0) begin
            $display("FAIL idle_rsp_early: got %b want 0", rsp1);
            n_fail++;
        end
        tick();
        n_run++;
        if (rsp1 !== 1'b1 || sw_rdat1 !== 64'hA5) begin
            $display("FAIL idle_rsp: got rsp=%b rdat=%h want 1 a5", rsp1, sw_rdat1);
            n_fail++;
        end
        tick();
        n_run++;
        if (rsp1 !== 1'b0) begin
            $display("FAIL idle_rsp_pulse: got %b want 0", rsp1);
            n_fail++;
        end
    endtask

    task automatic test_contention();
        tick();
        hw_req1 = 1'b1; hw_we1 = 1'b0; hw_add1 = 15'h20;
        sw_cs1 = 1'b1; sw_add1 = 15'h10; yield1 = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (hw_gnt1 !== 1'b1 || grant1 !== 1'b0) begin
                $display("FAIL contend_hw[%0d]: got hw_gnt=%b grant=%b want 1 0",
                    i, hw_gnt1, grant1);
                n_fail++;
            end
            tick();
        end
        yield1 = 1'b1;
        #1;
        n_run++;
        if (grant1 !== 1'b1 || hw_gnt1 !== 1'b0 || mem_add1 !== 15'h10) begin
            $display("FAIL yield_grant: got grant=%b hw_gnt=%b add=%h want 1 0 0010",
                grant1, hw_gnt1, mem_add1);
            n_fail++;
        end
        tick();
        sw_cs1 = 1'b0; yield1 = 1'b0;
        #1;
        n_run++;
        if (hw_gnt1 !== 1'b1 || grant1 !== 1'b0 || mem_add1 !== 15'h20) begin
            $display("FAIL hw_kept: got hw_gnt=%b grant=%b add=%h want 1 0 0020",
                hw_gnt1, grant1, mem_add1);
            n_fail++;
        end
        tick();
        hw_req1 = 1'b0;
        #1;
        n_run++;
        if (hw_gnt1 !== 1'b0 || mem_cs1 !== 1'b0) begin
            $display("FAIL hw_release: got hw_gnt=%b cs=%b want 0 0", hw_gnt1, mem_cs1);
            n_fail++;
        end
        repeat (4) tick();
        n_run++;
        if (hw_rdat1 !== 64'h5A || sw_rdat1 !== 64'hA5) begin
            $display("FAIL contend_data: got hw=%h sw=%h want 5a a5", hw_rdat1, sw_rdat1);
            n_fail++;
        end
    endtask

    task automatic test_compare();
        tick();
        sw_cs1 = 1'b1; sw_ce1 = 1'b1; sw_we1 = 1'b1;
        sw_add1 = 15'h2345; sw_wdat1 = 64'hDEAD;
        #1;
        n_run++;
        if (grant1 !== 1'b1 || mem_we1 !== 1'b0 || mem_wdat1 !== 64'h0) begin
            $display("FAIL cmp_mux: got grant=%b we=%b wdat=%h want 1 0 0",
                grant1, mem_we1, mem_wdat1);
            n_fail++;
        end
        tick();
        sw_cs1 = 1'b0; sw_ce1 = 1'b0; sw_we1 = 1'b0;
        tick();
        n_run++;
        if (rsp1 !== 1'b1 || sw_match1 !== 1'b1 || sw_aindex1 !== 14'h2345
            || sw_rdat1 !== 64'hA5) begin
            $display("FAIL cmp_hit: got rsp=%b m=%b idx=%h rdat=%h want 1 1 2345 a5",
                rsp1, sw_match1, sw_aindex1, sw_rdat1);
            n_fail++;
        end
        tick();
        sw_cs1 = 1'b1; sw_ce1 = 1'b1;
        sw_add1 = 15'h4ABC; sw_wdat1 = 64'hBEEF;
        tick();
        sw_cs1 = 1'b0; sw_ce1 = 1'b0;
        tick();
        n_run++;
        if (rsp1 !== 1'b1 || sw_match1 !== 1'b0 || sw_aindex1 !== 14'h0ABC
            || sw_rdat1 !== 64'hA5) begin
            $display("FAIL cmp_miss: got rsp=%b m=%b idx=%h rdat=%h want 1 0 0abc a5",
                rsp1, sw_match1, sw_aindex1, sw_rdat1);
            n_fail++;
        end
    endtask

    task automatic test_write_read();
        int w0;
        w0 = wr_cnt1;
        tick();
        sw_cs1 = 1'b1; sw_we1 = 1'b1; sw_add1 = 15'h7; sw_wdat1 = 64'h123;
        #1;
        n_run++;
        if (grant1 !== 1'b1 || mem_we1 !== 1'b1 || mem_wdat1 !== 64'h123) begin
            $display("FAIL wr_mux: got grant=%b we=%b wdat=%h want 1 1 123",
                grant1, mem_we1, mem_wdat1);
            n_fail++;
        end
        tick();
        sw_we1 = 1'b0; sw_wdat1 = 64'h0;
        tick();
        sw_cs1 = 1'b0;
        n_run++;
        if (rsp1 !== 1'b0) begin
            $display("FAIL wr_no_rsp: got %b want 0", rsp1);
            n_fail++;
        end
        tick();
        n_run++;
        if (rsp1 !== 1'b1 || sw_rdat1 !== 64'h123) begin
            $display("FAIL wr_readback: got rsp=%b rdat=%h want 1 123", rsp1, sw_rdat1);
            n_fail++;
        end
        tick();
        n_run++;
        if (wr_cnt1 - w0 !== 1) begin
            $display("FAIL wr_count: got %0d want 1", wr_cnt1 - w0);
            n_fail++;
        end
    endtask

    task automatic test_lat3_interleave();
        tick();
        hw_req3 = 1'b1; hw_we3 = 1'b0; hw_add3 = 15'h100;
        #1;
        n_run++;
        if (hw_gnt3 !== 1'b1 || grant3 !== 1'b0) begin
            $display("FAIL l3_g0: got hw_gnt=%b grant=%b want 1 0", hw_gnt3, grant3);
            n_fail++;
        end
        tick();
        hw_req3 = 1'b0; sw_cs3 = 1'b1; sw_we3 = 1'b0; sw_add3 = 15'h200;
        #1;
        n_run++;
        if (grant3 !== 1'b1 || hw_gnt3 !== 1'b0) begin
            $display("FAIL l3_g1: got grant=%b hw_gnt=%b want 1 0", grant3, hw_gnt3);
            n_fail++;
        end
        tick();
        sw_cs3 = 1'b0; hw_req3 = 1'b1; hw_add3 = 15'h300;
        tick();
        hw_req3 = 1'b0;
        n_run++;
        if (hw_rvld3 !== 1'b0 || rsp3 !== 1'b0) begin
            $display("FAIL l3_c3: got hw_rvld=%b rsp=%b want 0 0", hw_rvld3, rsp3);
            n_fail++;
        end
        tick();
        n_run++;
        if (hw_rvld3 !== 1'b1 || rsp3 !== 1'b0 || hw_rdat3 !== 64'h1111) begin
            $display("FAIL l3_c4: got hw_rvld=%b rsp=%b hw=%h want 1 0 1111",
                hw_rvld3, rsp3, hw_rdat3);
            n_fail++;
        end
        tick();
        n_run++;
        if (rsp3 !== 1'b1 || hw_rvld3 !== 1'b0 || sw_rdat3 !== 64'h2222
            || hw_rdat3 !== 64'h1111) begin
            $display("FAIL l3_c5: got rsp=%b hw_rvld=%b sw=%h hw=%h want 1 0 2222 1111",
                rsp3, hw_rvld3, sw_rdat3, hw_rdat3);
            n_fail++;
        end
        tick();
        n_run++;
        if (hw_rvld3 !== 1'b1 || rsp3 !== 1'b0 || hw_rdat3 !== 64'h3333
            || sw_rdat3 !== 64'h2222) begin
            $display("FAIL l3_c6: got hw_rvld=%b rsp=%b hw=%h sw=%h want 1 0 3333 2222",
                hw_rvld3, rsp3, hw_rdat3, sw_rdat3);
            n_fail++;
        end
        tick();
        n_run++;
        if (hw_rvld3 !== 1'b0 || rsp3 !== 1'b0) begin
            $display("FAIL l3_c7: got hw_rvld=%b rsp=%b want 0 0", hw_rvld3, rsp3);
            n_fail++;
        end
    endtask

    task automatic test_reset_midflight();
        int p0;
        tick();
        hw_req3 = 1'b1; hw_we3 = 1'b0; hw_add3 = 15'h300;
        tick();
        hw_req3 = 1'b0; sw_cs3 = 1'b1; sw_we3 = 1'b0; sw_add3 = 15'h100;
        tick();
        sw_cs3 = 1'b0;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({rsp3, hw_rvld3, rsp1, hw_rvld1} !== 4'b0
            || sw_rdat3 !== 64'h0 || hw_rdat3 !== 64'h0) begin
            $display("FAIL rst_l3: got rsp=%b rvld=%b sw=%h hw=%h want 0 0 0 0",
                rsp3, hw_rvld3, sw_rdat3, hw_rdat3);
            n_fail++;
        end
        n_run++;
        if (sw_rdat1 !== 64'h0 || hw_rdat1 !== 64'h0 || sw_aindex1 !== 14'h0
            || sw_match1 !== 1'b0) begin
            $display("FAIL rst_l1: got sw=%h hw=%h idx=%h m=%b want 0 0 0 0",
                sw_rdat1, hw_rdat1, sw_aindex1, sw_match1);
            n_fail++;
        end
        tick();
        rst_n = 1'b1;
        p0 = pulse_cnt3;
        repeat (6) tick();
        n_run++;
        if (pulse_cnt3 - p0 !== 0) begin
            $display("FAIL rst_drop: got %0d pulses after release want 0", pulse_cnt3 - p0);
            n_fail++;
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bd_we1 = 1'b0; bd_we3 = 1'b0; bd_add = '0; bd_dat = '0;
        sw_cs1 = 0; sw_ce1 = 0; sw_we1 = 0; yield1 = 0;
        sw_add1 = '0; sw_wdat1 = '0;
        hw_req1 = 0; hw_we1 = 0; hw_add1 = '0; hw_wdat1 = '0;
        sw_cs3 = 0; sw_ce3 = 0; sw_we3 = 0; yield3 = 0;
        sw_add3 = '0; sw_wdat3 = '0;
        hw_req3 = 0; hw_we3 = 0; hw_add3 = '0; hw_wdat3 = '0;

        preload(1, 15'h10,   64'hA5);
        preload(1, 15'h20,   64'h5A);
        preload(1, 15'h2345, 64'hDEAD);
        preload(1, 15'h4ABC, 64'hDEAD);
        preload(3, 15'h100,  64'h1111);
        preload(3, 15'h200,  64'h2222);
        preload(3, 15'h300,  64'h3333);

        test_reset();
        tick();
        rst_n = 1'b1;
        tick();

        test_idle_read();
        test_contention();
        test_compare();
        test_write_read();
        test_lat3_interleave();
        test_reset_midflight();

        n_run++;
        if (cmp_viol !== 0) begin
            $display("FAIL cmp_overlap: got %0d overlapping compares want 0", cmp_viol);
            n_fail++;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
